// File: rtl/hilo_divider_ctrl_if.sv
// Issue/HI-LO access bundle between the control unit and the divider/HI-LO owner.
// master = control unit side, slave = divider side.
interface hilo_divider_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             mf_req;
    logic             mt_we;
    logic             hilo_sel;
    logic [WIDTH-1:0] mt_data;
    logic             flush;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] mf_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, mf_req, mt_we, hilo_sel, mt_data, flush,
        input  busy, done, stall, mf_data, hi, lo, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, mf_req, mt_we, hilo_sel, mt_data, flush,
        output busy, done, stall, mf_data, hi, lo, div_by_zero
    );
endinterface

// File: rtl/hilo_divider_ctrl.sv
// Multi-cycle restoring DIV/DIVU sequencer that owns HI/LO and stalls dependent
// HI/LO accesses (or a second divide) until the running divide has retired.
module hilo_divider_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    hilo_divider_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;       // dividend shifts out of the top while quotient bits enter at the bottom
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             dvd_neg, dvs_neg, dbz;
    logic             accept, busy;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign rem_ge = (rem_sh >= {1'b0, dvs_mag});
    assign q_fix  = (dvd_neg ^ dvs_neg) ? -quo : quo;
    assign r_fix  = dvd_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE, DONE: begin
                accept   = bus.start & ~bus.flush;
                state_nx = IDLE;
                if (accept) state_nx = (bus.divisor == '0) ? FIXUP : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (bus.flush)                 state_nx = IDLE;
                else if (count == CW'(1))      state_nx = FIXUP;
            end
            FIXUP: begin
                busy     = 1'b1;
                state_nx = bus.flush ? IDLE : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs_mag <= '0;
            dvd_raw <= '0;
            dvd_neg <= 1'b0;
            dvs_neg <= 1'b0;
            dbz     <= 1'b0;
        end else if (accept) begin
            dvd_neg <= bus.is_signed & bus.dividend[WIDTH-1];
            dvs_neg <= bus.is_signed & bus.divisor[WIDTH-1];
            quo     <= (bus.is_signed & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
            dvs_mag <= (bus.is_signed & bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
            dvd_raw <= bus.dividend;
            rem     <= '0;
            count   <= CW'(WIDTH);
            dbz     <= (bus.divisor == '0);
        end else if (state == CALC) begin
            rem   <= rem_ge ? (rem_sh - {1'b0, dvs_mag}) : rem_sh;
            quo   <= {quo[WIDTH-2:0], rem_ge};
            count <= count - CW'(1);
        end
    end

    // A flushed FIXUP must leave HI/LO untouched; MT writes only land while not busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state == FIXUP && !bus.flush) begin
            lo_r <= dbz ? '1 : q_fix;
            hi_r <= dbz ? dvd_raw : r_fix;
        end else if (bus.mt_we && !busy) begin
            if (bus.hilo_sel) hi_r <= bus.mt_data;
            else              lo_r <= bus.mt_data;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = (state == DONE);
    assign bus.stall       = busy & (bus.mf_req | bus.mt_we | bus.start);
    assign bus.mf_data     = bus.hilo_sel ? hi_r : lo_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_hilo_divider_ctrl.sv
// Scoreboard bench for hilo_divider_ctrl: issued divides push reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_hilo_divider_ctrl;
    localparam int W = 32;

    logic clock, reset;
    int   tests = 0, fails = 0;
    logic [64:0] exp_q[$];   // {div_by_zero, hi, lo}

    hilo_divider_ctrl_if #(.WIDTH(W)) bus ();
    hilo_divider_ctrl #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation for signed.
    function automatic logic [64:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        q = x / y;
        r = x % y;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    always @(negedge clock) begin
        logic [64:0] e;
        if (reset && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("lo", bus.lo, e[31:0]);
                check("hi", bus.hi, e[63:32]);
                check("div_by_zero", bus.div_by_zero, e[64]);
                check("mf_data_done", bus.mf_data, bus.hilo_sel ? e[63:32] : e[31:0]);
            end
        end
    end

    // Called at posedge+1; holds start until the DUT can take it, returns at posedge+1.
    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        bit acc = 0;
        bus.start = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clock);
            if (!bus.stall && !bus.flush) begin
                acc = 1;
                exp_q.push_back(model(sgn, a, b));
            end
            @(posedge clock); #1;
        end
        bus.start = 1'b0;
        if (!acc) check("issue_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output int done_at, output int busy_n);
        done_at = 0; busy_n = 0;
        issue(sgn, a, b);
        for (int k = 1; k < 200; k++) begin
            @(negedge clock);
            if (bus.busy) busy_n++;
            if (bus.done) begin done_at = k; break; end
        end
        @(posedge clock); #1;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            seen = bus.done;
        end
        @(posedge clock); #1;
        if (!seen) check("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int  da, bn;
        bit  seen;
        logic [31:0] a, b;
        bit  sgn;
        bus.start = 0; bus.is_signed = 0; bus.dividend = 0; bus.divisor = 0;
        bus.mf_req = 0; bus.mt_we = 0; bus.hilo_sel = 0; bus.mt_data = 0; bus.flush = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check("reset_outputs", {bus.busy, bus.done, bus.stall, bus.div_by_zero, bus.hi, bus.lo}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        run_lat(0, 257, 16, da, bn);
        check("lat_done_257_16", da, W + 2);
        check("busy_cycles", bn, W + 1);
        check("lo_257_16", bus.lo, 16);
        check("hi_257_16", bus.hi, 1);

        issue(1, 32'hFFFF_FFF9, 32'h2); wait_done();
        check("lo_m7_2", bus.lo, 32'hFFFF_FFFD);
        check("hi_m7_2", bus.hi, 32'hFFFF_FFFF);
        issue(1, 32'h7, 32'hFFFF_FFFE); wait_done();
        check("lo_7_m2", bus.lo, 32'hFFFF_FFFD);
        check("hi_7_m2", bus.hi, 1);

        run_lat(0, 32'h1234, 0, da, bn);
        check("lat_dbz", da, 2);
        check("dbz_flag", bus.div_by_zero, 1);
        check("lo_dbz", bus.lo, 32'hFFFF_FFFF);
        check("hi_dbz", bus.hi, 32'h1234);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        check("dbz_cleared", bus.div_by_zero, 0);
        check("lo_ovf", bus.lo, 32'h8000_0000);
        check("hi_ovf", bus.hi, 0);

        // dependent MFLO plus a second divide arriving mid-flight
        issue(0, 100, 7);
        bus.mf_req = 1; bus.hilo_sel = 0;
        seen = 0;
        for (int k = 1; k < 100 && !seen; k++) begin
            @(negedge clock);
            if (bus.busy) check("stall_busy", bus.stall, 1);
            if (bus.done) begin
                seen = 1;
                check("stall_done", bus.stall, 0);
                check("mf_data_14", bus.mf_data, 14);
                exp_q.push_back(model(0, 50, 5));
            end
            @(posedge clock); #1;
            if (k == 4) begin
                bus.start = 1; bus.is_signed = 0; bus.dividend = 50; bus.divisor = 5;
            end
        end
        bus.start = 0; bus.mf_req = 0;
        if (!seen) check("stall_test_timeout", 64'd1, 64'd0);
        wait_done();
        check("lo_second", bus.lo, 10);

        // MTLO while idle, then a flushed divide
        bus.mt_we = 1; bus.hilo_sel = 0; bus.mt_data = 32'hCAFE;
        @(posedge clock); #1;
        bus.mt_we = 0;
        check("mtlo", bus.lo, 32'hCAFE);
        bus.start = 1; bus.flush = 1; bus.dividend = 50; bus.divisor = 5;
        @(negedge clock);
        @(posedge clock); #1;
        check("flush_beats_start", bus.busy, 0);
        bus.flush = 0;
        @(posedge clock); #1;
        bus.start = 0;
        check("busy_after_start", bus.busy, 1);
        repeat (8) @(posedge clock);
        #1 bus.flush = 1;
        @(posedge clock); #1;
        bus.flush = 0;
        @(negedge clock);
        check("busy_after_flush", bus.busy, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) seen = 1;
        end
        check("no_done_after_flush", seen, 0);
        check("lo_kept", bus.lo, 32'hCAFE);
        @(posedge clock); #1;

        // async reset mid-divide
        issue(0, 1000, 3);
        bus.mf_req = 1;
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        #1 check("reset_mid", {bus.busy, bus.done, bus.stall, bus.div_by_zero, bus.hi, bus.lo}, 64'd0);
        exp_q.delete();
        bus.mf_req = 0;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        issue(0, 9, 3); wait_done();
        check("lo_9_3", bus.lo, 3);
        check("hi_9_3", bus.hi, 0);

        // randomized back-to-back divides
        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       begin a = $urandom; b = 0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3:    begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            issue(sgn, a, b);
        end
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clock);
        #1 check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
